// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer: FSM encodings, reset seed, tap positions
// and the pure next-state / seed-guard helpers.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    localparam logic [7:0]  LFSR_RESET_SEED = 8'h01;
    localparam int unsigned LFSR_TAP_A      = 32'd4;
    localparam int unsigned LFSR_TAP_B      = 32'd3;
    localparam int unsigned LFSR_TAP_C      = 32'd2;
    localparam int unsigned LFSR_TAP_D      = 32'd0;

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        logic fb_s;
        fb_s = r[LFSR_TAP_A] ^ r[LFSR_TAP_B] ^ r[LFSR_TAP_C] ^ r[LFSR_TAP_D];
        return {fb_s, r[7:1]};
    endfunction

    // An all-zero state would lock the LFSR forever, so it is replaced by the reset seed.
    function automatic logic [7:0] seed_guard(input logic [7:0] s);
        logic [7:0] g_s;
        if (s == 8'h00) begin
            g_s = LFSR_RESET_SEED;
        end else begin
            g_s = s;
        end
        return g_s;
    endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register with synchronous load (zero-guarded) and advance.
module lfsr8_core
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] value
);

    logic [7:0] value_r;

    // LFSR state: load has priority over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= LFSR_RESET_SEED;
        end else if (load) begin
            value_r <= seed_guard(seed);
        end else if (advance) begin
            value_r <= lfsr_next(value_r);
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR sequencer: synchronized/debounced manual step, prescaled auto-run and seed load
// around an lfsr8_core.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 32'd16,
    parameter int unsigned TICK_DIV   = 32'd1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        seed_load,
    input  logic [7:0]  seed,
    output logic [7:0]  random,
    output logic        step_pulse,
    output logic [15:0] step_cnt,
    output logic [1:0]  mode
);

    localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 32'd1);
    localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 32'd1);

    logic        btn_meta_r, btn_sync_r;
    logic        run_meta_r, run_sync_r;
    logic [15:0] deb_cnt_r;
    logic        deb_level_r, deb_prev_r;
    logic [23:0] presc_r;
    seq_state_e  state_r;
    logic        step_pulse_r;
    logic [15:0] step_cnt_r;
    logic        deb_rise_s, deb_fall_s, tick_s, advance_s;

    // Two-flop synchronizers for the raw button and switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            run_meta_r <= 1'b0;
            run_sync_r <= 1'b0;
        end else begin
            btn_meta_r <= step_btn;
            btn_sync_r <= btn_meta_r;
            run_meta_r <= run_sw;
            run_sync_r <= run_meta_r;
        end
    end

    // Debounce: accept a new level after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_r   <= 16'd0;
            deb_level_r <= 1'b0;
            deb_prev_r  <= 1'b0;
        end else begin
            deb_prev_r <= deb_level_r;
            if (btn_sync_r != deb_level_r) begin
                if (deb_cnt_r == DEB_LAST) begin
                    deb_level_r <= btn_sync_r;
                    deb_cnt_r   <= 16'd0;
                end else begin
                    deb_cnt_r <= deb_cnt_r + 16'd1;
                end
            end else begin
                deb_cnt_r <= 16'd0;
            end
        end
    end

    assign deb_rise_s = deb_level_r & ~deb_prev_r;
    assign deb_fall_s = ~deb_level_r & deb_prev_r;
    assign tick_s     = (presc_r == TICK_LAST);

    // Advance request for this cycle; a coincident load swallows it.
    always_comb begin
        advance_s = 1'b0;
        if (seed_load) begin
            advance_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: advance_s = ~run_sync_r & deb_rise_s;
                ST_RUN:  advance_s = run_sync_r & tick_s;
                ST_HOLD: advance_s = 1'b0;
                default: advance_s = 1'b0;
            endcase
        end
    end

    // Sequencer FSM and auto-run prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            presc_r <= 24'd0;
        end else if (seed_load) begin
            state_r <= state_r;
            presc_r <= 24'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    presc_r <= 24'd0;
                    if (run_sync_r) begin
                        state_r <= ST_RUN;
                    end else if (deb_rise_s) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    presc_r <= 24'd0;
                    if (run_sync_r) begin
                        state_r <= ST_RUN;
                    end else if (deb_fall_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_RUN: begin
                    if (!run_sync_r) begin
                        state_r <= ST_IDLE;
                        presc_r <= 24'd0;
                    end else if (tick_s) begin
                        state_r <= ST_RUN;
                        presc_r <= 24'd0;
                    end else begin
                        state_r <= ST_RUN;
                        presc_r <= presc_r + 24'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    presc_r <= 24'd0;
                end
            endcase
        end
    end

    // Step strobe and advance counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pulse_r <= 1'b0;
            step_cnt_r   <= 16'd0;
        end else begin
            step_pulse_r <= seed_load | advance_s;
            if (seed_load) begin
                step_cnt_r <= 16'd0;
            end else if (advance_s) begin
                step_cnt_r <= step_cnt_r + 16'd1;
            end else begin
                step_cnt_r <= step_cnt_r;
            end
        end
    end

    lfsr8_core u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (seed_load),
        .seed    (seed),
        .advance (advance_s),
        .value   (random)
    );

    assign step_pulse = step_pulse_r;
    assign step_cnt   = step_cnt_r;
    assign mode       = state_r;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed + randomized bench for lfsr_seq_ctrl against an arithmetic reference model.
module tb_lfsr_seq_ctrl;

    localparam int DEB  = 4;
    localparam int TDIV = 8;

    logic        clk = 1'b0;
    logic        rst_n, step_btn, run_sw, seed_load;
    logic [7:0]  seed, random;
    logic        step_pulse;
    logic [15:0] step_cnt;
    logic [1:0]  mode;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_q[$];
    logic [7:0]  m_rand;
    logic [15:0] m_cnt;

    lfsr_seq_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
        .clk(clk), .rst_n(rst_n), .step_btn(step_btn), .run_sw(run_sw),
        .seed_load(seed_load), .seed(seed), .random(random),
        .step_pulse(step_pulse), .step_cnt(step_cnt), .mode(mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (step_pulse === 1'b1) pulse_q.push_back(cyc);

    function automatic logic [7:0] ref_next(input logic [7:0] r);
        int v, fb;
        v  = int'(r);
        fb = ((v >> 4) ^ (v >> 3) ^ (v >> 2) ^ v) & 1;
        return 8'((v >> 1) | (fb << 7));
    endfunction

    task automatic model_adv();
        m_rand = ref_next(m_rand);
        m_cnt  = m_cnt + 16'd1;
    endtask

    task automatic model_load(input logic [7:0] s);
        m_rand = (s == 8'h00) ? 8'h01 : s;
        m_cnt  = 16'd0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic manual_press(input string tag);
        int n0;
        n0 = pulse_q.size();
        step_btn = 1'b1;
        tick(10);
        chk({tag, "_hold_mode"}, 32'(mode), 32'd2);
        step_btn = 1'b0;
        tick(10);
        chk({tag, "_idle_mode"}, 32'(mode), 32'd0);
        chk({tag, "_pulses"}, 32'(pulse_q.size() - n0), 32'd1);
        model_adv();
        chk({tag, "_random"}, 32'(random), 32'(m_rand));
        chk({tag, "_cnt"}, 32'(step_cnt), 32'(m_cnt));
    endtask

    task automatic do_load(input logic [7:0] s);
        seed_load = 1'b1;
        seed      = s;
        tick(1);
        seed_load = 1'b0;
        seed      = $urandom_range(0, 255);
        model_load(s);
    endtask

    logic [7:0] exp5 [5];
    int n0, k, w;
    logic [7:0] s;

    initial begin
        exp5[0] = 8'h80; exp5[1] = 8'h40; exp5[2] = 8'h20; exp5[3] = 8'h10; exp5[4] = 8'h88;
        rst_n = 1'b0; step_btn = 1'b0; run_sw = 1'b0; seed_load = 1'b0; seed = 8'h00;
        tick(3);
        chk("rst_random", 32'(random), 32'h01);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        chk("rst_cnt", 32'(step_cnt), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        rst_n = 1'b1;
        m_rand = 8'h01; m_cnt = 16'd0;
        tick(2);

        // five clean presses
        for (int i = 0; i < 5; i++) begin
            manual_press("press");
            chk("press_const", 32'(random), 32'(exp5[i]));
        end
        chk("press_cnt5", 32'(step_cnt), 32'd5);

        // bouncing presses: first the 2-cycle pattern, then random widths below DEB
        for (int i = 0; i < 4; i++) begin
            n0 = pulse_q.size();
            w = (i == 0) ? 2 : $urandom_range(1, DEB - 1);
            step_btn = 1'b1; tick(w);
            step_btn = 1'b0; tick((i == 0) ? 2 : $urandom_range(1, DEB - 1));
            step_btn = 1'b1; tick(w);
            tick(12);
            step_btn = 1'b0;
            tick(12);
            chk("bounce_pulses", 32'(pulse_q.size() - n0), 32'd1);
            model_adv();
            chk("bounce_random", 32'(random), 32'(m_rand));
        end

        // seed loads
        do_load(8'h00);
        chk("load0_random", 32'(random), 32'h01);
        chk("load0_cnt", 32'(step_cnt), 32'd0);
        chk("load0_pulse", 32'(step_pulse), 32'd1);
        chk("load0_mode", 32'(mode), 32'd0);
        tick(1);
        chk("load0_pulse_end", 32'(step_pulse), 32'd0);
        do_load(8'hFF);
        tick(1);
        manual_press("ff_step");
        chk("ff_step_const", 32'(random), 32'h7F);
        for (int i = 0; i < 4; i++) begin
            s = 8'($urandom_range(0, 255));
            do_load(s);
            chk("rload_random", 32'(random), 32'(m_rand));
            tick(1);
            manual_press("rload_step");
        end

        // auto-run with button activity
        run_sw = 1'b1;
        k = 0;
        while (mode !== 2'd1 && k < 20) begin tick(1); k++; end
        chk("run_enter", 32'(mode), 32'd1);
        pulse_q.delete();
        tick(3);
        step_btn = 1'b1; tick(12);
        step_btn = 1'b0; tick(25);
        chk("run_pulses", 32'(pulse_q.size()), 32'd5);
        for (int i = 1; i < pulse_q.size(); i++)
            chk("run_spacing", 32'(pulse_q[i] - pulse_q[i-1]), 32'd8);
        for (int i = 0; i < pulse_q.size(); i++) model_adv();
        chk("run_random", 32'(random), 32'(m_rand));
        chk("run_cnt", 32'(step_cnt), 32'(m_cnt));
        chk("run_mode", 32'(mode), 32'd1);

        // seed load coincident with a tick
        n0 = pulse_q.size();
        k = 0;
        while (pulse_q.size() == n0 && k < 20) begin tick(1); k++; end
        chk("tick_found", 32'(pulse_q.size() - n0), 32'd1);
        tick(7);
        do_load(8'hAA);
        chk("coin_random", 32'(random), 32'hAA);
        chk("coin_cnt", 32'(step_cnt), 32'd0);
        chk("coin_pulse", 32'(step_pulse), 32'd1);
        n0 = pulse_q.size();
        tick(7);
        chk("coin_no_tick", 32'(pulse_q.size() - n0), 32'd0);
        tick(1);
        chk("coin_next_tick", 32'(pulse_q.size() - n0), 32'd1);
        model_adv();
        chk("coin_next_random", 32'(random), 32'(m_rand));
        run_sw = 1'b0;
        tick(6);
        chk("run_exit_mode", 32'(mode), 32'd0);

        // reset mid-run
        run_sw = 1'b1;
        k = 0;
        while (mode !== 2'd1 && k < 20) begin tick(1); k++; end
        n0 = pulse_q.size();
        k = 0;
        while (pulse_q.size() == n0 && k < 20) begin tick(1); k++; end
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("arst_random", 32'(random), 32'h01);
        chk("arst_mode", 32'(mode), 32'd0);
        chk("arst_cnt", 32'(step_cnt), 32'd0);
        chk("arst_pulse", 32'(step_pulse), 32'd0);
        tick(1);
        rst_n = 1'b1;
        m_rand = 8'h01; m_cnt = 16'd0;
        n0 = pulse_q.size();
        k = 0;
        while (pulse_q.size() == n0 && k < 40) begin tick(1); k++; end
        chk("resume_latency", 32'(k), 32'd11);
        chk("resume_mode", 32'(mode), 32'd1);
        model_adv();
        chk("resume_random", 32'(random), 32'(m_rand));
        chk("resume_cnt", 32'(step_cnt), 32'(m_cnt));
        run_sw = 1'b0;
        tick(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
